// File: rtl/mod_beep_seq.sv
// Beep-pattern sequencer upstream of mod_buzzer: queues {dur, gap} requests, triggers the buzzer, waits out the gap.
// Optional buzzer-handshake timeout with sticky err_o when BEEP_SEQ_TIMEOUT_EN is defined.
module mod_beep_seq #(
    parameter int BUZ_PERIOD_MS = 3000,
    parameter int GAP_MS_MAX    = 1000,
    parameter int DEPTH         = 8,
    parameter int TIMEOUT_MS    = 10,
    parameter int simulation    = 0
) (
    input  logic                           clk_i_1MHz,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    input  logic [$clog2(BUZ_PERIOD_MS):0] req_dur_ms_i,
    input  logic [$clog2(GAP_MS_MAX):0]    req_gap_ms_i,
    output logic                           req_ready_o,
    input  logic                           flush_i,
    input  logic                           buz_cyc_i,
    output logic [$clog2(BUZ_PERIOD_MS):0] buz_period_o,
    output logic                           buz_trig_o,
    output logic                           busy_o,
    output logic [$clog2(DEPTH):0]         level_o,
    output logic                           err_o
);
    localparam int DW = $clog2(BUZ_PERIOD_MS) + 1;
    localparam int GW = $clog2(GAP_MS_MAX) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_TRIG, ST_BEEP, ST_GAP} state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
    logic [DW-1:0]     period_reg, period_next;
    logic              trig_reg;
    logic [9:0]        presc_reg;
    logic              tick;
    logic              to_fire;

    logic [DW+GW-1:0]  fifo_mem [DEPTH];
    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic [DW+GW-1:0]  head;
    logic              push, pop, empty, full;

    // ---------------- request FIFO (pointers carry one wrap bit) ----------------
    assign level_o     = wr_ptr_reg - rd_ptr_reg;
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (level_o == FULL_LVL);
    assign req_ready_o = !full;
    // Flush wins over a same-cycle push or pop.
    assign push        = req_valid_i && !full && !flush_i;
    assign pop         = (state_reg == ST_IDLE) && !empty && !flush_i;
    assign head        = fifo_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i_1MHz) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {req_dur_ms_i, req_gap_ms_i};
        end
    end

    always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // ---------------- ms tick ----------------
    always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
        if (rst_i) begin
            presc_reg <= '0;
        end else if (presc_reg == 10'd999) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 10'd1;
        end
    end

    assign tick = (simulation != 0) || (presc_reg == 10'd999);

    // ---------------- optional handshake timeout ----------------
`ifdef BEEP_SEQ_TIMEOUT_EN
    localparam int TW = ((DW > $clog2(TIMEOUT_MS + 1)) ? DW : $clog2(TIMEOUT_MS + 1)) + 2;
    logic [TW-1:0] to_cnt_reg;
    logic [TW-1:0] to_limit;
    logic          err_reg;

    assign to_limit = (state_reg == ST_BEEP) ? (TW'(period_reg) + TW'(TIMEOUT_MS)) : TW'(TIMEOUT_MS);
    // Fires on the tick that completes the limit, only while the expected cyc edge is still missing.
    assign to_fire  = tick && ((to_cnt_reg + TW'(1)) >= to_limit) &&
                      (((state_reg == ST_TRIG) && !buz_cyc_i) || ((state_reg == ST_BEEP) && buz_cyc_i));

    always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                to_cnt_reg <= '0;
            end else if (tick && ((state_reg == ST_TRIG) || (state_reg == ST_BEEP))) begin
                to_cnt_reg <= to_cnt_reg + TW'(1);
            end
            if (to_fire) err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign to_fire = 1'b0;
    assign err_o   = (TIMEOUT_MS < 0);
`endif

    // ---------------- sequencer FSM ----------------
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        period_next  = period_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    period_next  = head[GW +: DW];
                    gap_cnt_next = head[GW-1:0];
                    state_next   = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (buz_cyc_i)    state_next = ST_BEEP;
                else if (to_fire) state_next = ST_GAP;
            end
            ST_BEEP: begin
                if (!buz_cyc_i || to_fire) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (flush_i || (gap_cnt_reg == '0)) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    gap_cnt_next = gap_cnt_reg - GW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i_1MHz or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
            period_reg  <= '0;
            trig_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            period_reg  <= period_next;
            trig_reg    <= (state_next == ST_TRIG);
        end
    end

    assign buz_trig_o   = trig_reg;
    assign buz_period_o = period_reg;
    assign busy_o       = (state_reg != ST_IDLE) || !empty;

endmodule

// File: tb/tb_mod_beep_seq.sv
// Self-checking bench for mod_beep_seq with a behavioural buzzer and a queue-based expectation model.
module tb_mod_beep_seq;
    localparam int DEPTH      = 8;
    localparam int TIMEOUT_MS = 10;
    localparam int DW         = $clog2(3000) + 1;
    localparam int GW         = $clog2(1000) + 1;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          flush = 1'b0;
    logic          cyc = 1'b0;
    logic [DW-1:0] req_dur = '0;
    logic [GW-1:0] req_gap = '0;
    logic          req_ready, trig, busy, err;
    logic [DW-1:0] period;
    logic [LW-1:0] level;

    int n_cmp = 0;
    int n_fail = 0;
    bit buz_en = 1'b1;
    int obs_period[$];
    int obs_interval[$];
    int exp_dur[$];
    int exp_gap[$];

    mod_beep_seq #(
        .BUZ_PERIOD_MS(3000), .GAP_MS_MAX(1000), .DEPTH(DEPTH),
        .TIMEOUT_MS(TIMEOUT_MS), .simulation(1)
    ) dut (
        .clk_i_1MHz(clk), .rst_i(rst), .req_valid_i(req_valid),
        .req_dur_ms_i(req_dur), .req_gap_ms_i(req_gap), .req_ready_o(req_ready),
        .flush_i(flush), .buz_cyc_i(cyc), .buz_period_o(period), .buz_trig_o(trig),
        .busy_o(busy), .level_o(level), .err_o(err)
    );

    always #500 clk = ~clk;

    // Behavioural buzzer (cyc high for dur+2 cycles per trigger) plus trigger recorder.
    initial begin
        int buz_cnt;
        int fall_age;
        logic trig_prev;
        buz_cnt = 0;
        fall_age = -1;
        trig_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 1'b0;
                buz_cnt = 0;
                fall_age = -1;
                trig_prev = 1'b0;
            end else begin
                if (fall_age >= 0) fall_age++;
                if (trig && !trig_prev) begin
                    obs_period.push_back(int'(period));
                    obs_interval.push_back((fall_age >= 0) ? fall_age - 1 : -1);
                    $display("beep: period=%0d edges_since_cyc_fall=%0d level=%0d", period,
                             (fall_age >= 0) ? fall_age - 1 : -1, level);
                    fall_age = -1;
                end
                if (buz_cnt > 0) begin
                    buz_cnt--;
                    if (buz_cnt == 0) begin
                        cyc = 1'b0;
                        fall_age = 0;
                    end
                end else if (buz_en && trig && !cyc) begin
                    cyc = 1'b1;
                    buz_cnt = int'(period) + 2;
                end
                trig_prev = trig;
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_req(input int d, input int g);
        req_valid = 1'b1;
        req_dur = DW'(d);
        req_gap = GW'(g);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && !cyc && !trig) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic clear_model();
        obs_period.delete();
        obs_interval.delete();
        exp_dur.delete();
        exp_gap.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
        n_cmp++; if (period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit seen, ok;
        int gap_cycles;
        clear_model();
        drive_req(5, 3);
        seen = trig;
        for (int i = 0; i < 2 && !seen; i++) begin
            step();
            seen = trig;
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_push_to_trig: trig=%b want 1 by 2nd edge", seen); end
        n_cmp++; if (period !== DW'(5)) begin n_fail++; $display("FAIL single_period: got %0d want 5", period); end
        for (int i = 0; i < 50 && !cyc; i++) step();
        for (int i = 0; i < 50 && cyc; i++) step();
        gap_cycles = 0;
        for (int i = 0; i < 50 && busy; i++) begin
            step();
            gap_cycles++;
        end
        gap_cycles = gap_cycles - 1;
        n_cmp++; if (gap_cycles < 3 || gap_cycles > 4) begin n_fail++; $display("FAIL single_gap_len: got %0d want 3..4", gap_cycles); end
        wait_quiet(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_quiet: busy=%b want 0 within bound", busy); end
        n_cmp++; if (obs_period.size() !== 1) begin n_fail++; $display("FAIL single_trig_count: got %0d want 1", obs_period.size()); end
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL single_level: got %0d want 0", level); end
    endtask

    task automatic run_burst(input string name);
        bit ok;
        for (int k = 0; k < exp_dur.size(); k++) drive_req(exp_dur[k], exp_gap[k]);
        wait_quiet(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_quiet: busy=%b want 0 within bound", name, busy); end
        n_cmp++; if (obs_period.size() !== exp_dur.size()) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, obs_period.size(), exp_dur.size()); end
        for (int k = 0; k < exp_dur.size() && k < obs_period.size(); k++) begin
            n_cmp++; if (obs_period[k] !== exp_dur[k]) begin n_fail++; $display("FAIL %s_period[%0d]: got %0d want %0d", name, k, obs_period[k], exp_dur[k]); end
            if (k > 0) begin
                n_cmp++;
                if (obs_interval[k] < exp_gap[k-1] + 2 || obs_interval[k] > exp_gap[k-1] + 3) begin
                    n_fail++;
                    $display("FAIL %s_interval[%0d]: got %0d want %0d..%0d", name, k, obs_interval[k], exp_gap[k-1] + 2, exp_gap[k-1] + 3);
                end
            end
        end
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL %s_level: got %0d want 0", name, level); end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_model();
        exp_dur = '{2, 4, 1};
        exp_gap = '{0, 1, 2};
        run_burst("b2b_fixed");
        repeat (3) begin
            clear_model();
            n = $urandom_range(6, 3);
            for (int k = 0; k < n; k++) begin
                exp_dur.push_back($urandom_range(6, 0));
                exp_gap.push_back($urandom_range(4, 0));
            end
            run_burst("b2b_rand");
        end
    endtask

    task automatic test_fill();
        int d, g;
        bit ok;
        clear_model();
        // First entry is a long beep so the queue backs up behind it.
        for (int k = 0; k < DEPTH + 3; k++) begin
            d = (k == 0) ? 40 : int'($urandom_range(6, 0));
            g = (k == 0) ? 0 : int'($urandom_range(3, 0));
            if (k <= DEPTH) exp_dur.push_back(d);
            req_valid = 1'b1;
            req_dur = DW'(d);
            req_gap = GW'(g);
            step();
        end
        req_valid = 1'b0;
        n_cmp++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fill_level: got %0d want %0d", level, DEPTH); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", req_ready); end
        for (int i = 0; i < 300 && level == LW'(DEPTH); i++) step();
        n_cmp++; if (level !== LW'(DEPTH - 1)) begin n_fail++; $display("FAIL fill_after_pop: got %0d want %0d", level, DEPTH - 1); end
        d = $urandom_range(6, 0);
        exp_dur.push_back(d);
        drive_req(d, 0);
        n_cmp++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fill_refill: got %0d want %0d", level, DEPTH); end
        wait_quiet(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL fill_quiet: busy=%b want 0 within bound", busy); end
        n_cmp++; if (obs_period.size() !== exp_dur.size()) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", obs_period.size(), exp_dur.size()); end
        for (int k = 0; k < exp_dur.size() && k < obs_period.size(); k++) begin
            n_cmp++; if (obs_period[k] !== exp_dur[k]) begin n_fail++; $display("FAIL fill_period[%0d]: got %0d want %0d", k, obs_period[k], exp_dur[k]); end
        end
    endtask

    task automatic test_flush();
        bit ok;
        clear_model();
        drive_req(10, 1);
        for (int k = 0; k < 4; k++) drive_req($urandom_range(6, 0), $urandom_range(3, 0));
        for (int i = 0; i < 20 && !cyc; i++) step();
        n_cmp++; if (level !== LW'(4)) begin n_fail++; $display("FAIL flush_level_before: got %0d want 4", level); end
        flush = 1'b1;
        req_valid = 1'b1;
        req_dur = DW'(3);
        req_gap = GW'(0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL flush_level_after: got %0d want 0", level); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_beep_continues: busy=%b want 1", busy); end
        wait_quiet(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL flush_quiet: busy=%b want 0 within bound", busy); end
        repeat (20) step();
        n_cmp++; if (obs_period.size() !== 1) begin n_fail++; $display("FAIL flush_trig_count: got %0d want 1", obs_period.size()); end
        n_cmp++; if (obs_period.size() > 0 && obs_period[0] !== 10) begin n_fail++; $display("FAIL flush_period: got %0d want 10", obs_period[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d;
        clear_model();
        buz_en = 1'b0;
        for (int k = 0; k < 3; k++) drive_req($urandom_range(6, 0), 0);
        for (int i = 0; i < 5 && !trig; i++) step();
        #100;
        rst = 1'b1;
        #1;
        n_cmp++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rstmid_trig_async: got %b want 0", trig); end
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", level); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err); end
        step();
        rst = 1'b0;
        buz_en = 1'b1;
        repeat (10) step();
        n_cmp++; if (busy !== 1'b0 || trig !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: busy=%b trig=%b want 0 0", busy, trig); end
        n_cmp++; if (obs_period.size() !== 1) begin n_fail++; $display("FAIL rstmid_trig_count: got %0d want 1", obs_period.size()); end
        d = $urandom_range(6, 0);
        drive_req(d, 1);
        wait_quiet(ok);
        n_cmp++; if (!ok || obs_period.size() !== 2) begin n_fail++; $display("FAIL rstmid_serve: beeps=%0d want 2", obs_period.size()); end
        n_cmp++; if (obs_period.size() == 2 && obs_period[1] !== d) begin n_fail++; $display("FAIL rstmid_period: got %0d want %0d", obs_period[1], d); end
    endtask

`ifdef BEEP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int high_cnt, d;
        clear_model();
        buz_en = 1'b0;
        drive_req(3, 1);
        for (int i = 0; i < 5 && !trig; i++) step();
        high_cnt = 0;
        for (int i = 0; i < 100 && trig; i++) begin
            high_cnt++;
            step();
        end
        n_cmp++; if (high_cnt < TIMEOUT_MS || high_cnt > TIMEOUT_MS + 1) begin n_fail++; $display("FAIL timeout_trig_len: got %0d want %0d..%0d", high_cnt, TIMEOUT_MS, TIMEOUT_MS + 1); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
        buz_en = 1'b1;
        wait_quiet(ok);
        d = $urandom_range(6, 0);
        drive_req(d, 0);
        wait_quiet(ok);
        n_cmp++; if (!ok || obs_period.size() !== 2) begin n_fail++; $display("FAIL timeout_next_served: beeps=%0d want 2", obs_period.size()); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_flush();
        test_reset_mid();
`ifdef BEEP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
